// File: rtl/relu_pool_unit_if.sv
// Handshake bundle between the Psum register file, relu_pool_unit and the
// pooled-output consumer.
interface relu_pool_unit_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH*28-1:0] two_rows;
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_WIDTH-1:0]    out_data;
  logic [5:0]               out_addr;
  logic                     out_valid;
  logic                     out_ready;
  logic                     tile_done;

  modport master (
    output two_rows, in_valid, out_ready,
    input  in_ready, out_data, out_addr, out_valid, tile_done
  );

  modport slave (
    input  two_rows, in_valid, out_ready,
    output in_ready, out_data, out_addr, out_valid, tile_done
  );
endinterface

// File: rtl/relu_pool_unit.sv
// ReLU + 2x2 max-pool over a two-row 14-pixel bfloat16 bundle; emits 7 pooled
// beats per bundle, tagged with their 7x7 tile address, and flags tile completion.
module relu_pool_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int ROW_PIXELS = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  relu_pool_unit_if.slave  bus
);
  localparam int NE = 2 * ROW_PIXELS;
  localparam int PC = ROW_PIXELS / 2;

  typedef enum logic {IDLE, EMIT} state_t;
  typedef logic [NE-1:0][DATA_WIDTH-1:0] bundle_t;

  state_t                state_q;
  bundle_t               buf_q;
  logic [2:0]            row_q, col_q, col_d;
  logic [DATA_WIDTH-1:0] out_data_q, pool_d;
  logic [5:0]            out_addr_q, addr_d;
  logic                  tile_done_q;

  function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-1] ? '0 : x;
  endfunction

  // Element k sits at packed index NE-1-k (element 0 is the MSB slice).
  // Post-ReLU values are non-negative, so raw unsigned compare orders them.
  function automatic logic [DATA_WIDTH-1:0] pool(input bundle_t b, input logic [2:0] c);
    logic [DATA_WIDTH-1:0] m, v;
    int idx;
    m = '0;
    for (int j = 0; j < 4; j++) begin
      idx = 2 * int'(c) + (j / 2) * ROW_PIXELS + (j % 2);
      v = relu(b[NE-1-idx]);
      if (v > m) m = v;
    end
    return m;
  endfunction

  // Outputs are registered one beat ahead: on accept we pool column 0 straight
  // from the incoming bundle, on each beat we pool the next column from buf_q.
  always_comb begin
    col_d  = (state_q == IDLE) ? 3'd0 : col_q + 3'd1;
    pool_d = (state_q == IDLE) ? pool(bus.two_rows, 3'd0) : pool(buf_q, col_d);
    addr_d = 6'(row_q) * 6'd7 + 6'(col_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      tile_done_q <= 1'b0;
    end else begin
      tile_done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.in_valid) begin
          buf_q      <= bus.two_rows;
          col_q      <= col_d;
          out_data_q <= pool_d;
          out_addr_q <= addr_d;
          state_q    <= EMIT;
        end
        EMIT: if (bus.out_ready) begin
          if (col_q == 3'(PC - 1)) begin
            state_q <= IDLE;
            if (row_q == 3'(PC - 1)) begin
              row_q       <= '0;
              tile_done_q <= 1'b1;
            end else begin
              row_q <= row_q + 3'd1;
            end
          end else begin
            col_q      <= col_d;
            out_data_q <= pool_d;
            out_addr_q <= addr_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.tile_done = tile_done_q;
endmodule
